// File: rtl/mole_countdown_timer.sv
// Millisecond timebase plus saturating up/down counter feeding the mole FSM.
// A load strobe seeds the count (e.g. from the LFSR) and restarts the timebase.
module mole_countdown_timer #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned INIT_VALUE  = 2046
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] timer_value,
  output logic             tick_ms,
  output logic             expired
);

  localparam int unsigned PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_INIT   = WIDTH'(INIT_VALUE);

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = enable && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      timer_q <= CNT_INIT;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
    end
  end

  // Load wins over a coincident wrap: the step is dropped and the timebase restarts.
  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    tick_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      timer_d = load_value;
    end else if (enable) begin
      if (wrap) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (up && (timer_q != CNT_MAX)) begin
          timer_d = timer_q + 1'b1;
        end else if (!up && (timer_q != '0)) begin
          timer_d = timer_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign timer_value = timer_q;
  assign tick_ms     = tick_q;
  assign expired     = up ? (timer_q == CNT_MAX) : (timer_q == '0);

endmodule

// File: tb/tb_mole_countdown_timer.sv
// Directed bench for mole_countdown_timer with a 4-cycle timebase.
module tb_mole_countdown_timer;

  localparam int unsigned WIDTH = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] timer_value;
  logic             tick_ms;
  logic             expired;

  int errors = 0;
  int checks = 0;

  mole_countdown_timer #(
    .WIDTH      (WIDTH),
    .CLKS_PER_MS(4),
    .INIT_VALUE (2046)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .timer_value(timer_value),
    .tick_ms    (tick_ms),
    .expired    (expired)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load_value = v;
    load       = 1'b1;
    step_clk();
    load       = 1'b0;
  endtask

  task automatic check_state(input string tag, input int tv, input int tk, input int ex);
    check({tag, ".timer"},   32'(timer_value), 32'(tv));
    check({tag, ".tick"},    32'(tick_ms),     32'(tk));
    check({tag, ".expired"}, 32'(expired),     32'(ex));
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    up         = 1'b0;
    load       = 1'b0;
    load_value = '0;
    repeat (2) step_clk();
    reset = 1'b0;
    check_state("rst_init", 2046, 0, 0);

    // 1. async reset between edges, then idle with enable=0
    do_load(11'd100);
    check("load100", 32'(timer_value), 32'd100);
    #2;
    reset = 1'b1;
    #1;
    check_state("rst_async", 2046, 0, 0);
    step_clk();
    reset = 1'b0;
    repeat (10) step_clk();
    check_state("rst_idle", 2046, 0, 0);

    // 2. down count from reset value
    enable = 1'b1;
    up     = 1'b0;
    repeat (3) step_clk();
    check_state("down_e3", 2046, 0, 0);
    step_clk();
    check_state("down_e4", 2045, 1, 0);
    step_clk();
    check_state("down_e5", 2045, 0, 0);
    repeat (3) step_clk();
    check_state("down_e8", 2044, 1, 0);

    // 3. saturation at zero
    enable = 1'b0;
    do_load(11'd2);
    check_state("sat0_load", 2, 0, 0);
    enable = 1'b1;
    repeat (4) step_clk();
    check_state("sat0_1", 1, 1, 0);
    repeat (4) step_clk();
    check_state("sat0_0", 0, 1, 1);
    repeat (3) step_clk();
    check_state("sat0_mid", 0, 0, 1);
    step_clk();
    check_state("sat0_hold", 0, 1, 1);

    // 4. up count to max
    enable = 1'b0;
    up     = 1'b1;
    do_load(11'd2045);
    check_state("up_load", 2045, 0, 0);
    enable = 1'b1;
    repeat (4) step_clk();
    check_state("up_2046", 2046, 1, 0);
    repeat (4) step_clk();
    check_state("up_2047", 2047, 1, 1);
    repeat (4) step_clk();
    check_state("up_hold", 2047, 1, 1);
    up = 1'b0;
    #1;
    check("exp_dir", 32'(expired), 32'd0);

    // 5a. pause mid-interval (prescaler at 0, counting down from 2047)
    repeat (2) step_clk();
    enable = 1'b0;
    repeat (3) step_clk();
    check_state("pause_hold", 2047, 0, 0);
    enable = 1'b1;
    step_clk();
    check_state("pause_e3", 2047, 0, 0);
    step_clk();
    check_state("pause_e4", 2046, 1, 0);

    // 5b. load coincident with a wrap
    repeat (3) step_clk();
    check_state("prio_pre", 2046, 0, 0);
    do_load(11'd500);
    check_state("prio_load", 500, 0, 0);
    repeat (3) step_clk();
    check_state("prio_e3", 500, 0, 0);
    step_clk();
    check_state("prio_e4", 499, 1, 0);

    // 6. reset while counting with prescaler=2
    do_load(11'd1000);
    repeat (2) step_clk();
    check_state("rst_mid_pre", 1000, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_state("rst_mid", 2046, 0, 0);
    step_clk();
    check_state("rst_held", 2046, 0, 0);
    reset = 1'b0;
    repeat (3) step_clk();
    check_state("rst_rel_e3", 2046, 0, 0);
    step_clk();
    check_state("rst_rel_e4", 2045, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
